// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the sequential multiplier that
//                borrows the execute-stage ALU.
//                  seq_state_t : sequencer states (IDLE, ADD_LO, ADD_HI, SHIFT,
//                                DONE)
//                  OP_ALU      : ALU opcode used by all sequencer operations
//                  ALU_NAND / ALU_ADD / ALU_ADDC : ALU function codes
//                  FLAG_C      : carry bit position in the ALU flag vector
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADD_LO = 3'd1,
        ADD_HI = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam logic [2:0] OP_ALU   = 3'b000;

    localparam logic [3:0] ALU_NAND = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_ADDC = 4'b0010;

    localparam int         FLAG_C   = 0;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : alu_port_mux
//  Description : Combinational selector for the ALU control/operand ports.
//                Idle  : execute-stage controls pass straight through.
//                Busy  : the sequencer owns the ALU. Outside its add/addc
//                        cycles the ALU is held in bubble with neutral
//                        operands so the flag register is left alone.
//  Ports       : i_busy           sequencer owns the ALU
//                i_seq_add        sequencer is issuing an add/addc this cycle
//                i_seq_alu_op     add/addc function code from the sequencer
//                i_seq_s_1/_s_2   sequencer operands
//                i_pipe_*         execute-stage ALU controls
//                o_alu_*          controls presented to the ALU
//  Revision    : 1.0  initial release
// ============================================================================
module alu_port_mux
    import alu_seq_pkg::*;
(
    input  logic        i_busy,
    input  logic        i_seq_add,
    input  logic [3:0]  i_seq_alu_op,
    input  logic [15:0] i_seq_s_1,
    input  logic [15:0] i_seq_s_2,
    input  logic [2:0]  i_pipe_op,
    input  logic [3:0]  i_pipe_alu_op,
    input  logic [15:0] i_pipe_s_1,
    input  logic [15:0] i_pipe_s_2,
    input  logic        i_pipe_bubble,
    output logic [2:0]  o_alu_op,
    output logic [3:0]  o_alu_alu_op,
    output logic [15:0] o_alu_s_1,
    output logic [15:0] o_alu_s_2,
    output logic        o_alu_bubble
);

    always_comb begin
        o_alu_op     = i_pipe_op;
        o_alu_alu_op = i_pipe_alu_op;
        o_alu_s_1    = i_pipe_s_1;
        o_alu_s_2    = i_pipe_s_2;
        o_alu_bubble = i_pipe_bubble;

        if (i_busy) begin
            o_alu_op     = OP_ALU;
            o_alu_alu_op = i_seq_add ? i_seq_alu_op : ALU_NAND;
            o_alu_s_1    = i_seq_add ? i_seq_s_1    : 16'h0000;
            o_alu_s_2    = i_seq_add ? i_seq_s_2    : 16'h0000;
            // Only the add/addc cycles may touch the ALU flag register.
            o_alu_bubble = ~i_seq_add;
        end
    end

endmodule : alu_port_mux
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Multi-cycle unsigned 16x16->32 shift-and-add multiplier that
//                reuses the execute-stage ALU. Each set multiplier bit costs
//                an add of the low words followed by an add-with-carry of the
//                high words; the carry between them lives in the ALU's own
//                registered flag, so no adder is instantiated here.
//                Build option ALU_MUL_EARLY_TERM_EN: finish as soon as the
//                remaining multiplier bits are all zero.
//  Parameters  : MUL_BITS  multiplier bits processed (<= 16)
//                CNT_W     bit-counter width (2**CNT_W > MUL_BITS)
//  Ports       : clk, rst_n                clock / async active-low reset
//                start_i, a_i, b_i          multiply request and operands
//                pipe_*_i                   execute-stage ALU controls
//                alu_*_o                    controls presented to the ALU
//                alu_result_i, alu_flags_i  ALU result / registered flags
//                busy_o, stall_o            sequencer active / pipeline stall
//                done_o, product_o          completion pulse / held product
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int MUL_BITS = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [2:0]  pipe_op_i,
    input  logic [3:0]  pipe_alu_op_i,
    input  logic [15:0] pipe_s_1_i,
    input  logic [15:0] pipe_s_2_i,
    input  logic        pipe_bubble_i,
    output logic [2:0]  alu_op_o,
    output logic [3:0]  alu_alu_op_o,
    output logic [15:0] alu_s_1_o,
    output logic [15:0] alu_s_2_o,
    output logic        alu_bubble_o,
    input  logic [15:0] alu_result_i,
    input  logic [3:0]  alu_flags_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] product_o
);

    seq_state_t         r_state;
    logic [31:0]        r_mcand;
    logic [15:0]        r_mplier;
    logic [15:0]        r_prod_lo;
    logic [15:0]        r_prod_hi;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    logic [31:0]        r_product;

    logic [CNT_W-1:0]   w_count_nxt;
    logic [15:0]        w_mplier_shr;
    logic               w_last;
    logic               w_busy;
    logic               w_seq_add;
    logic               w_seq_hi;
    logic [3:0]         w_seq_alu_op;
    logic [15:0]        w_seq_s_1;
    logic [15:0]        w_seq_s_2;

    // The ALU feeds its carry back to itself for addc, so the flag vector
    // is not needed here; it is kept on the port list for the ALU hookup.
    logic               w_unused_flags;
    assign w_unused_flags = ^alu_flags_i;

    assign w_count_nxt  = r_count + 1'b1;
    assign w_mplier_shr = r_mplier >> 1;

`ifdef ALU_MUL_EARLY_TERM_EN
    assign w_last = (w_count_nxt == CNT_W'(MUL_BITS)) || (w_mplier_shr == 16'h0000);
`else
    assign w_last = (w_count_nxt == CNT_W'(MUL_BITS));
`endif

    assign w_busy       = (r_state != IDLE);
    assign w_seq_add    = (r_state == ADD_LO) || (r_state == ADD_HI);
    assign w_seq_hi     = (r_state == ADD_HI);
    assign w_seq_alu_op = w_seq_hi ? ALU_ADDC        : ALU_ADD;
    assign w_seq_s_1    = w_seq_hi ? r_prod_hi       : r_prod_lo;
    assign w_seq_s_2    = w_seq_hi ? r_mcand[31:16]  : r_mcand[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mcand   <= 32'h0;
            r_mplier  <= 16'h0;
            r_prod_lo <= 16'h0;
            r_prod_hi <= 16'h0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_product <= 32'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_mcand   <= {16'h0000, a_i};
                        r_mplier  <= b_i;
                        r_prod_lo <= 16'h0;
                        r_prod_hi <= 16'h0;
                        r_count   <= '0;
                        r_state   <= b_i[0] ? ADD_LO : SHIFT;
                    end
                end
                ADD_LO: begin
                    r_prod_lo <= alu_result_i;
                    r_state   <= ADD_HI;
                end
                ADD_HI: begin
                    r_prod_hi <= alu_result_i;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_count  <= w_count_nxt;
                    if (w_last) begin
                        // Product and done land on the same edge.
                        r_product <= {r_prod_hi, r_prod_lo};
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state <= w_mplier_shr[0] ? ADD_LO : SHIFT;
                    end
                end
                DONE: begin
                    // start_i is deliberately not sampled here.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    alu_port_mux u_alu_port_mux (
        .i_busy        (w_busy),
        .i_seq_add     (w_seq_add),
        .i_seq_alu_op  (w_seq_alu_op),
        .i_seq_s_1     (w_seq_s_1),
        .i_seq_s_2     (w_seq_s_2),
        .i_pipe_op     (pipe_op_i),
        .i_pipe_alu_op (pipe_alu_op_i),
        .i_pipe_s_1    (pipe_s_1_i),
        .i_pipe_s_2    (pipe_s_2_i),
        .i_pipe_bubble (pipe_bubble_i),
        .o_alu_op      (alu_op_o),
        .o_alu_alu_op  (alu_alu_op_o),
        .o_alu_s_1     (alu_s_1_o),
        .o_alu_s_2     (alu_s_2_o),
        .o_alu_bubble  (alu_bubble_o)
    );

    assign busy_o    = w_busy;
    assign stall_o   = w_busy;
    assign done_o    = r_done;
    assign product_o = r_product;

endmodule : alu_mul_seq
`default_nettype wire
